// File: rtl/otp_ctrl_lci_seq_pkg.sv
// Shared types for the life-cycle programming sequencer: OTP command/error codes,
// the escalation encoding and the sparse FSM state encoding.
package otp_ctrl_lci_seq_pkg;

  localparam int unsigned OtpSizeWidth     = 2;
  localparam int unsigned OtpIfWidth       = 64;
  localparam int unsigned ScrmblBlockWidth = 64;

  typedef enum logic [3:0] {
    On  = 4'b0101,
    Off = 4'b1010
  } lc_tx_t;

  typedef enum logic [1:0] {
    Read  = 2'b00,
    Write = 2'b01
  } cmd_e;

  typedef enum logic [2:0] {
    NoError              = 3'h0,
    MacroError           = 3'h1,
    MacroEccCorrError    = 3'h2,
    MacroEccUncorrError  = 3'h3,
    MacroWriteBlankError = 3'h4,
    AccessError          = 3'h5,
    CheckFailError       = 3'h6,
    FsmStateError        = 3'h7
  } otp_err_e;

  // Each state repeats an even-parity nibble three times, so any two states differ
  // in at least 6 bits; a register stuck at all-zero lands in ErrorSt.
  typedef enum logic [11:0] {
    ResetSt     = 12'h333,
    IdleSt      = 12'h555,
    SelSt       = 12'h666,
    WriteSt     = 12'h999,
    WriteWaitSt = 12'haaa,
    ReadSt      = 12'hccc,
    ReadWaitSt  = 12'hfff,
    ErrorSt     = 12'h000
  } state_e;

  function automatic int unsigned vbits(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/otp_ctrl_lci_seq_cnt.sv
// Redundant word counter: an up-count and a down-count that must always sum to all-ones.
module otp_ctrl_lci_seq_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             incr_i,
  output logic [Width-1:0] cnt_o,
  output logic             err_o
);

  logic [Width-1:0] up_d, up_q, dn_d, dn_q, sum;

  always_comb begin
    up_d = up_q;
    dn_d = dn_q;
    if (clr_i) begin
      up_d = '0;
      dn_d = '1;
    end else if (incr_i) begin
      up_d = up_q + Width'(1);
      dn_d = dn_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      up_q <= '0;
      dn_q <= '1;
    end else begin
      up_q <= up_d;
      dn_q <= dn_d;
    end
  end

  assign sum   = up_q + dn_q;
  assign cnt_o = up_q;
  assign err_o = (sum != '1);

endmodule

// File: rtl/otp_ctrl_lci_seq.sv
// Life-cycle programming sequencer: latches a transition vector and burns it word by word.
// Define OTP_CTRL_LCI_VERIFY_EN to read back and compare every written word.
module otp_ctrl_lci_seq
  import otp_ctrl_lci_seq_pkg::*;
#(
  parameter int unsigned             NumWords      = 10,
  parameter int unsigned             OtpWidth      = 16,
  parameter int unsigned             OtpAddrWidth  = 10,
  parameter logic [OtpAddrWidth-1:0] BaseAddr      = '0,
  parameter bit                      SkipZeroWords = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  lc_tx_t                        escalate_en_i,
  input  logic                          req_i,
  input  logic [NumWords*OtpWidth-1:0]  data_i,
  output logic                          ack_o,
  output logic                          err_o,
  output otp_err_e                      error_o,
  output logic                          fsm_err_o,
  output logic                          idle_o,
  output logic                          otp_req_o,
  output cmd_e                          otp_cmd_o,
  output logic [OtpSizeWidth-1:0]       otp_size_o,
  output logic [OtpAddrWidth-1:0]       otp_addr_o,
  output logic [OtpIfWidth-1:0]         otp_wdata_o,
  input  logic                          otp_gnt_i,
  input  logic                          otp_rvalid_i,
  input  logic [ScrmblBlockWidth-1:0]   otp_rdata_i,
  input  otp_err_e                      otp_err_i
);

  localparam int unsigned           CntWidth = vbits(NumWords);
  localparam logic [CntWidth-1:0]   LastCnt  = CntWidth'(NumWords - 1);

  state_e   state_d, state_q;
  otp_err_e error_d, error_q;
  logic     ack_d, ack_q, err_d, err_q;
  logic [NumWords-1:0][OtpWidth-1:0] data_d, data_q;
  logic [OtpWidth-1:0] word;
  logic [CntWidth-1:0] cnt_q;
  logic cnt_clr, cnt_incr, cnt_mismatch, cnt_err, advance, illegal;
  logic unused_rdata;

  otp_ctrl_lci_seq_cnt #(
    .Width (CntWidth)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .incr_i (cnt_incr),
    .cnt_o  (cnt_q),
    .err_o  (cnt_mismatch)
  );

  assign word    = data_q[cnt_q];
  assign cnt_err = cnt_mismatch || (cnt_q > LastCnt);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d   = state_q;
    error_d   = error_q;
    data_d    = data_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    idle_o    = 1'b0;
    fsm_err_o = 1'b0;
    otp_req_o = 1'b0;
    otp_cmd_o = Read;
    cnt_clr   = 1'b0;
    cnt_incr  = 1'b0;
    advance   = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      ResetSt: if (en_i) state_d = IdleSt;
      IdleSt: begin
        idle_o = 1'b1;
        if (req_i) begin
          data_d  = data_i;
          cnt_clr = 1'b1;
          state_d = SelSt;
        end
      end
      SelSt: begin
        if (SkipZeroWords && (word == '0)) advance = 1'b1;
        else                               state_d = WriteSt;
      end
      WriteSt: begin
        otp_req_o = 1'b1;
        otp_cmd_o = Write;
        if (otp_gnt_i) state_d = WriteWaitSt;
      end
      WriteWaitSt: begin
        if (otp_rvalid_i) begin
          if (error_d == NoError) error_d = otp_err_i;
`ifdef OTP_CTRL_LCI_VERIFY_EN
          if (otp_err_i == NoError) state_d = ReadSt;
          else                      advance = 1'b1;
`else
          advance = 1'b1;
`endif
        end
      end
`ifdef OTP_CTRL_LCI_VERIFY_EN
      ReadSt: begin
        otp_req_o = 1'b1;
        otp_cmd_o = Read;
        if (otp_gnt_i) state_d = ReadWaitSt;
      end
      ReadWaitSt: begin
        if (otp_rvalid_i) begin
          if (error_d == NoError) begin
            if (otp_err_i != NoError)                   error_d = otp_err_i;
            else if (otp_rdata_i[OtpWidth-1:0] != word) error_d = CheckFailError;
          end
          advance = 1'b1;
        end
      end
`endif
      ErrorSt: begin
        idle_o = 1'b1;
        if (error_q == NoError) error_d = FsmStateError;
      end
      default: illegal = 1'b1;
    endcase

    if (advance) begin
      if (cnt_q == LastCnt) begin
        ack_d   = 1'b1;
        err_d   = (error_d != NoError);
        state_d = (error_d != NoError) ? ErrorSt : IdleSt;
      end else begin
        cnt_incr = 1'b1;
        state_d  = SelSt;
      end
    end

    // Faults win over everything: any in-flight response is dropped and no ack is sent.
    if ((escalate_en_i != Off) || cnt_err || illegal) begin
      state_d   = ErrorSt;
      fsm_err_o = 1'b1;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      cnt_clr   = 1'b0;
      cnt_incr  = 1'b0;
      otp_req_o = 1'b0;
      otp_cmd_o = Read;
      data_d    = data_q;
      error_d   = (error_q == NoError) ? FsmStateError : error_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      state_q <= ResetSt;
      error_q <= NoError;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      // NOTE: the data latch is reset too, so a stale vector never reaches the macro.
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign ack_o        = ack_q;
  assign err_o        = err_q;
  assign error_o      = error_q;
  assign otp_size_o   = '0;
  assign otp_addr_o   = BaseAddr + OtpAddrWidth'(cnt_q);
  assign otp_wdata_o  = otp_req_o ? OtpIfWidth'(word) : '0;
  assign unused_rdata = ^otp_rdata_i;

endmodule

// File: tb/tb_otp_ctrl_lci_seq.sv
// Scoreboard bench for otp_ctrl_lci_seq: expected OTP commands and acks are queued by
// the stimulus and consumed by a monitor; a second instance checks all-zero latency.
module tb_otp_ctrl_lci_seq;
  import otp_ctrl_lci_seq_pkg::*;

  typedef struct packed {
    cmd_e        cmd;
    logic [9:0]  addr;
    logic [63:0] wdata;
  } exp_cmd_t;

  typedef struct packed {
    logic     err;
    otp_err_e code;
  } exp_ack_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en_i;
  lc_tx_t escalate_en_i;
  logic req_i;
  logic [63:0] data_i;
  logic ack_o, err_o, fsm_err_o, idle_o, otp_req_o;
  otp_err_e error_o;
  cmd_e otp_cmd_o;
  logic [1:0] otp_size_o;
  logic [9:0] otp_addr_o;
  logic [63:0] otp_wdata_o;
  logic otp_gnt_i, otp_rvalid_i;
  logic [63:0] otp_rdata_i;
  otp_err_e otp_err_i;

  lc_tx_t esc10;
  logic req10;
  logic [159:0] data10;
  logic ack10, err10, fsm_err10, idle10, otp_req10;
  otp_err_e error10;
  cmd_e cmd10;
  logic [1:0] size10;
  logic [9:0] addr10;
  logic [63:0] wdata10;

  int checks = 0;
  int errors = 0;
  int rsp_delay = 0;
  exp_cmd_t exp_cmd_q[$];
  exp_ack_t exp_ack_q[$];
  otp_err_e rsp_err_q[$];
  logic [15:0] rd_q[$];

  always #5 clk = ~clk;

  assign otp_gnt_i = otp_req_o;

  otp_ctrl_lci_seq #(
    .NumWords(4), .OtpWidth(16), .OtpAddrWidth(10), .BaseAddr(10'h040), .SkipZeroWords(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_i), .escalate_en_i(escalate_en_i),
    .req_i(req_i), .data_i(data_i), .ack_o(ack_o), .err_o(err_o), .error_o(error_o),
    .fsm_err_o(fsm_err_o), .idle_o(idle_o), .otp_req_o(otp_req_o), .otp_cmd_o(otp_cmd_o),
    .otp_size_o(otp_size_o), .otp_addr_o(otp_addr_o), .otp_wdata_o(otp_wdata_o),
    .otp_gnt_i(otp_gnt_i), .otp_rvalid_i(otp_rvalid_i), .otp_rdata_i(otp_rdata_i),
    .otp_err_i(otp_err_i)
  );

  otp_ctrl_lci_seq #(
    .NumWords(10), .OtpWidth(16), .OtpAddrWidth(10), .BaseAddr(10'h000), .SkipZeroWords(1'b1)
  ) dut10 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en_i), .escalate_en_i(esc10),
    .req_i(req10), .data_i(data10), .ack_o(ack10), .err_o(err10), .error_o(error10),
    .fsm_err_o(fsm_err10), .idle_o(idle10), .otp_req_o(otp_req10), .otp_cmd_o(cmd10),
    .otp_size_o(size10), .otp_addr_o(addr10), .otp_wdata_o(wdata10),
    .otp_gnt_i(1'b0), .otp_rvalid_i(1'b0), .otp_rdata_i(64'h0), .otp_err_i(NoError)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic exp_write(input logic [9:0] addr, input logic [15:0] d, input bit ok);
    exp_cmd_q.push_back('{cmd: Write, addr: addr, wdata: 64'(d)});
`ifdef OTP_CTRL_LCI_VERIFY_EN
    if (ok) exp_cmd_q.push_back('{cmd: Read, addr: addr, wdata: 64'(d)});
`else
    if (ok) begin end
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_seq(input logic [63:0] d);
    @(negedge clk);
    data_i = d;
    req_i  = 1'b1;
    @(posedge clk);
    #1 req_i = 1'b0;
  endtask

  task automatic wait_ack(input int bound, input string name);
    bit got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (ack_o) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: no ack within %0d cycles, expected one", name, bound);
    end
  endtask

  // OTP macro model: always grants, answers after rsp_delay extra cycles.
  initial begin
    bit is_write;
    logic [63:0] wd;
    otp_rvalid_i = 1'b0;
    otp_err_i    = NoError;
    otp_rdata_i  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && otp_req_o && otp_gnt_i) begin
        is_write = (otp_cmd_o == Write);
        wd       = otp_wdata_o;
        repeat (rsp_delay) @(posedge clk);
        @(posedge clk);
        #1 otp_rvalid_i = 1'b1;
        if (is_write) otp_err_i = (rsp_err_q.size() > 0) ? rsp_err_q.pop_front() : NoError;
        else          otp_rdata_i = (rd_q.size() > 0) ? 64'(rd_q.pop_front()) : wd;
        @(posedge clk);
        #1 otp_rvalid_i = 1'b0;
        otp_err_i   = NoError;
        otp_rdata_i = '0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_cmd_t ec;
    exp_ack_t ea;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (otp_req_o && otp_gnt_i) begin
          if (exp_cmd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cmd: got cmd=%0d addr=%h wdata=%h, expected none",
                     otp_cmd_o, otp_addr_o, otp_wdata_o);
          end else begin
            ec = exp_cmd_q.pop_front();
            check("cmd", 64'(otp_cmd_o), 64'(ec.cmd));
            check("addr", 64'(otp_addr_o), 64'(ec.addr));
            check("wdata", otp_wdata_o, ec.wdata);
            check("size", 64'(otp_size_o), 64'h0);
          end
        end else begin
          check("wdata_no_req", otp_wdata_o, 64'h0);
        end
        if (ack_o) begin
          if (exp_ack_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack err=%0d code=%0d, expected none", err_o, error_o);
          end else begin
            ea = exp_ack_q.pop_front();
            check("ack_err", 64'(err_o), 64'(ea.err));
            check("ack_code", 64'(error_o), 64'(ea.code));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int lat, nreq;
    logic e10;
    rst_n = 1'b0;
    en_i = 1'b0;
    escalate_en_i = Off;
    esc10 = Off;
    req_i = 1'b0;
    req10 = 1'b0;
    data_i = '0;
    data10 = '0;

    // Reset values.
    #12;
    check("rst_idle", 64'(idle_o), 64'h0);
    check("rst_ack", 64'(ack_o), 64'h0);
    check("rst_err", 64'(err_o), 64'h0);
    check("rst_error", 64'(error_o), 64'(NoError));
    check("rst_fsm_err", 64'(fsm_err_o), 64'h0);
    check("rst_req", 64'(otp_req_o), 64'h0);
    check("rst_cmd", 64'(otp_cmd_o), 64'(Read));
    check("rst_size", 64'(otp_size_o), 64'h0);
    check("rst_wdata", otp_wdata_o, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_st_idle", 64'(idle_o), 64'h0);
    en_i = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_en", 64'(idle_o), 64'h1);
    check("idle10_after_en", 64'(idle10), 64'h1);

    // All-zero vector on the 10-word instance: ack 11 cycles after the req is sampled.
    @(negedge clk);
    req10 = 1'b1;
    @(posedge clk);
    #1 req10 = 1'b0;
    got = 1'b0; lat = 0; nreq = 0; e10 = 1'b1;
    for (int i = 1; i <= 30 && !got; i++) begin
      @(negedge clk);
      if (otp_req10) nreq++;
      if (ack10) begin
        got = 1'b1;
        lat = i;
        e10 = err10;
      end
    end
    check("zero_latency", 64'(lat), 64'd11);
    check("zero_otp_reqs", 64'(nreq), 64'd0);
    check("zero_err", 64'(e10), 64'h0);

    // Sparse vector: only words 1 and 3 are written.
    exp_write(10'h041, 16'h0001, 1'b1);
    exp_write(10'h043, 16'h0003, 1'b1);
    exp_ack_q.push_back('{err: 1'b0, code: NoError});
    start_seq(64'h0003_0000_0001_0000);
    wait_ack(60, "sparse_ack");
    check("sparse_idle", 64'(idle_o), 64'h1);

    // Macro errors on words 1 and 2: first code kept, all words still written.
    rsp_err_q.push_back(NoError);
    rsp_err_q.push_back(MacroWriteBlankError);
    rsp_err_q.push_back(MacroError);
    rsp_err_q.push_back(NoError);
    exp_write(10'h040, 16'h0001, 1'b1);
    exp_write(10'h041, 16'h0002, 1'b0);
    exp_write(10'h042, 16'h0003, 1'b0);
    exp_write(10'h043, 16'h0004, 1'b1);
    exp_ack_q.push_back('{err: 1'b1, code: MacroWriteBlankError});
    start_seq(64'h0004_0003_0002_0001);
    wait_ack(80, "macro_err_ack");
    @(negedge clk);
    check("err_st_idle", 64'(idle_o), 64'h1);
    check("err_st_code", 64'(error_o), 64'(MacroWriteBlankError));
    start_seq(64'h0000_0000_0000_0007);
    repeat (10) @(negedge clk);
    check("err_st_no_req", 64'(otp_req_o), 64'h0);
    do_reset();
    check("reset_clears_error", 64'(error_o), 64'(NoError));

`ifdef OTP_CTRL_LCI_VERIFY_EN
    // Read-back mismatch on word 0.
    rd_q.push_back(16'h00FF);
    exp_write(10'h040, 16'h00F0, 1'b1);
    exp_ack_q.push_back('{err: 1'b1, code: CheckFailError});
    start_seq(64'h0000_0000_0000_00F0);
    wait_ack(60, "verify_ack");
    @(negedge clk);
    check("verify_err_st_idle", 64'(idle_o), 64'h1);
    do_reset();
`endif

    // Escalation while waiting for the write response.
    rsp_delay = 4;
    exp_write(10'h040, 16'h0005, 1'b0);
    start_seq(64'h0000_0000_0000_0005);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (otp_req_o && otp_gnt_i) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL esc_write_issue: no write within 20 cycles, expected one");
    end
    @(posedge clk);
    #1 escalate_en_i = On;
    @(negedge clk);
    check("esc_fsm_err", 64'(fsm_err_o), 64'h1);
    @(posedge clk);
    #1 escalate_en_i = Off;
    @(negedge clk);
    check("esc_err_st_idle", 64'(idle_o), 64'h1);
    check("esc_code", 64'(error_o), 64'(FsmStateError));
    check("esc_fsm_err_pulse", 64'(fsm_err_o), 64'h0);
    repeat (10) @(negedge clk);
    check("esc_no_req", 64'(otp_req_o), 64'h0);
    check("esc_code_held", 64'(error_o), 64'(FsmStateError));
    rsp_delay = 0;
    do_reset();

    // req_i held high across the ack, data_i changed mid-sequence.
    exp_write(10'h040, 16'h0011, 1'b1);
    exp_write(10'h041, 16'h0022, 1'b1);
    exp_ack_q.push_back('{err: 1'b0, code: NoError});
    exp_write(10'h040, 16'h0033, 1'b1);
    exp_ack_q.push_back('{err: 1'b0, code: NoError});
    @(negedge clk);
    data_i = 64'h0000_0000_0022_0011;
    req_i  = 1'b1;
    repeat (3) @(posedge clk);
    #1 data_i = 64'h0000_0000_0000_0033;
    wait_ack(60, "hold_ack1");
    @(posedge clk);
    #1 req_i = 1'b0;
    wait_ack(60, "hold_ack2");
    repeat (5) @(negedge clk);
    check("hold_idle", 64'(idle_o), 64'h1);

    check("cmd_queue_empty", 64'(exp_cmd_q.size()), 64'd0);
    check("ack_queue_empty", 64'(exp_ack_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
